// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a 2-entry prefetch FIFO and jump flush
// One outstanding memory request; a jump cancels anything fetched earlier.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        valid,
  input  logic        ready,
  input  logic        jmp,
  input  logic [31:0] jmp_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_addr  [2];

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_pop;
  logic [1:0]  w_count_post;
  logic [31:0] w_jmp_target;
  logic [31:0] w_pc_inc;
  logic        w_tail;
  logic        w_unused_jmp_lsbs;

  assign valid      = (r_count != 2'd0);
  assign instr      = r_fifo_instr[r_head];
  assign instr_addr = r_fifo_addr[r_head];
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;

  assign w_pop        = valid && ready && !jmp;
  assign w_push       = (r_state == S_FETCH) && mem_ack && !jmp;
  assign w_count_pop  = r_count - {1'b0, w_pop};
  assign w_count_post = w_count_pop + {1'b0, w_push};
  assign w_jmp_target = {jmp_addr[31:2], 2'b00};
  assign w_pc_inc     = r_pc + 32'd4;
  // A push only happens with count <= 1, so the tail is head xor count[0].
  assign w_tail       = r_head ^ r_count[0];
  assign w_unused_jmp_lsbs = &{1'b0, jmp_addr[1:0]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[w_tail] <= mem_data;
      r_fifo_addr[w_tail]  <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_ADDR;
      r_mem_addr <= RESET_ADDR;
      r_mem_rd   <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      r_count <= jmp ? 2'd0 : w_count_post;
      if (w_pop) begin
        r_head <= ~r_head;
      end

      case (r_state)
        S_IDLE: begin
          if (jmp) begin
            r_pc       <= w_jmp_target;
            r_mem_addr <= w_jmp_target;
            r_mem_rd   <= 1'b1;
            r_state    <= S_FETCH;
          end else if (w_count_pop != 2'd2) begin
            r_mem_rd <= 1'b1;
            r_state  <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (jmp) begin
            r_pc <= w_jmp_target;
            // Without the ack the old request must stay on the bus until it completes.
            if (mem_ack) begin
              r_mem_addr <= w_jmp_target;
            end else begin
              r_state <= S_DISCARD;
            end
          end else if (mem_ack) begin
            r_pc       <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (w_count_post == 2'd2) begin
              r_mem_rd <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end

        S_DISCARD: begin
          if (jmp) begin
            r_pc <= w_jmp_target;
          end
          if (mem_ack) begin
            r_mem_addr <= jmp ? w_jmp_target : r_pc;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_mem_rd <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Memory returns addr ^ 32'hDEAD_0000, either zero-wait or manually acked.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        valid;
  logic        ready;
  logic        jmp;
  logic [31:0] jmp_addr;

  logic        ack_auto;
  logic        ack_man;
  int          n_checks;
  int          n_fail;

  localparam logic [31:0] DMASK = 32'hDEAD_0000;

  assign mem_ack  = ack_auto ? mem_rd : ack_man;
  assign mem_data = mem_addr ^ DMASK;

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .instr      (instr),
    .instr_addr (instr_addr),
    .valid      (valid),
    .ready      (ready),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ready    = 1'b0;
    jmp      = 1'b0;
    jmp_addr = 32'h0;
    ack_auto = 1'b0;
    ack_man  = 1'b0;

    tick();
    tick();
    chk("reset_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // first request right after release, then zero-wait streaming
    tick();
    chk("first_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("first_mem_addr", mem_addr, 32'h0);
    chk("first_valid", {31'b0, valid}, 32'd0);
    ack_auto = 1'b1;
    ready    = 1'b1;
    tick();
    chk("stream0_valid", {31'b0, valid}, 32'd1);
    chk("stream0_addr", instr_addr, 32'h0);
    chk("stream0_instr", instr, 32'h0 ^ DMASK);
    chk("stream0_mem_addr", mem_addr, 32'h4);
    tick();
    chk("stream1_addr", instr_addr, 32'h4);
    chk("stream1_instr", instr, 32'h4 ^ DMASK);
    tick();
    chk("stream2_addr", instr_addr, 32'h8);
    tick();
    chk("stream3_addr", instr_addr, 32'hC);
    chk("stream3_valid", {31'b0, valid}, 32'd1);

    // asynchronous reset in the middle of a fetch
    rst = 1'b1;
    #1;
    chk("midrst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    ready = 1'b0;
    tick();
    rst = 1'b0;

    // backpressure: two entries buffer, then fetch stops
    tick();
    chk("bp_mem_rd_on", {31'b0, mem_rd}, 32'd1);
    chk("bp_refetch_addr", mem_addr, 32'h0);
    tick();
    chk("bp_head0", instr_addr, 32'h0);
    tick();
    chk("bp_idle_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("bp_idle_mem_addr", mem_addr, 32'h8);
    tick();
    tick();
    chk("bp_hold_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("bp_hold_valid", {31'b0, valid}, 32'd1);
    chk("bp_hold_head", instr_addr, 32'h0);
    ready = 1'b1;
    tick();
    chk("bp_drain1_addr", instr_addr, 32'h4);
    chk("bp_resume_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("bp_resume_addr", mem_addr, 32'h8);
    tick();
    chk("bp_drain2_addr", instr_addr, 32'h8);

    // slow memory, jump while the request is still outstanding
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    tick();
    chk("wait_valid", {31'b0, valid}, 32'd0);
    chk("wait_mem_addr", mem_addr, 32'hC);
    tick();
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0100;
    tick();
    jmp = 1'b0;
    chk("discard_mem_addr", mem_addr, 32'hC);
    chk("discard_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("discard_valid", {31'b0, valid}, 32'd0);
    ack_man = 1'b1;
    tick();
    chk("redirect_mem_addr", mem_addr, 32'h100);
    chk("redirect_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("redirect_head_valid", {31'b0, valid}, 32'd1);
    chk("redirect_head_addr", instr_addr, 32'h100);
    chk("redirect_head_instr", instr, 32'h100 ^ DMASK);

    // jump to an unaligned target coincident with the ack
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0203;
    tick();
    jmp     = 1'b0;
    ack_man = 1'b0;
    chk("jmpack_mem_addr", mem_addr, 32'h200);
    chk("jmpack_valid", {31'b0, valid}, 32'd0);
    chk("jmpack_mem_rd", {31'b0, mem_rd}, 32'd1);
    ack_auto = 1'b1;
    tick();
    chk("jmpack_head_valid", {31'b0, valid}, 32'd1);
    chk("jmpack_head_addr", instr_addr, 32'h200);
    chk("jmpack_next_mem_addr", mem_addr, 32'h204);

    // full FIFO, pop and jump together
    ready = 1'b0;
    tick();
    chk("full_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("full_head_addr", instr_addr, 32'h200);
    ready    = 1'b1;
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0300;
    tick();
    jmp = 1'b0;
    chk("popjmp_valid", {31'b0, valid}, 32'd0);
    chk("popjmp_mem_addr", mem_addr, 32'h300);
    chk("popjmp_mem_rd", {31'b0, mem_rd}, 32'd1);
    tick();
    chk("popjmp_head_valid", {31'b0, valid}, 32'd1);
    chk("popjmp_head_addr", instr_addr, 32'h300);
    chk("popjmp_head_instr", instr, 32'h300 ^ DMASK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
